// File: rtl/blk_unpacker_if.sv
// Block-in / word-out bus of the padded-block unpacker.
// The block source and the word consumer share this bundle on the master side.
interface blk_unpacker_if;
    logic [511:0] blk;
    logic         blk_vld;
    logic         blk_last;
    logic         blk_rdy;
    logic [31:0]  pkt;
    logic         pkt_vld;
    logic         pkt_rdy;
    logic         msg_done;
    logic [63:0]  mgln;
    logic         len_err;

    modport master (
        output blk, blk_vld, blk_last, pkt_rdy,
        input  blk_rdy, pkt, pkt_vld, msg_done, mgln, len_err
    );

    modport slave (
        input  blk, blk_vld, blk_last, pkt_rdy,
        output blk_rdy, pkt, pkt_vld, msg_done, mgln, len_err
    );
endinterface

// File: rtl/blk_unpacker.sv
// Strips padding from 512-bit padded blocks and streams the message as 32-bit words,
// recovering the 64-bit bit-length field and flagging inconsistent lengths.
module blk_unpacker (
    input  logic          clk,
    input  logic          rst,
    blk_unpacker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HEAD, WAIT, HELD, TAIL, FIN} state_t;
    state_t state, state_nxt;

    logic [511:0] blk_q;
    logic [63:0]  held;
    logic [63:0]  mgln_q;
    logic [31:0]  e_cnt;
    logic [3:0]   idx;
    logic [3:0]   tail_cnt;
    logic [1:0]   held_cnt;
    logic         last_q;
    logic         len_err_q;

    logic         accept;
    logic         xfer;
    logic         blk_rdy_c;
    logic         pkt_vld_c;
    logic         msg_done_c;
    logic [31:0]  pkt_c;

    logic [63:0]  len_f;
    logic [63:0]  n_f;
    logic [63:0]  e_f;
    logic [63:0]  h_f;
    logic [63:0]  r_f;
    logic         err_f;
    logic         empty_f;
    logic [1:0]   held_f;
    logic [3:0]   tail_f;

    function automatic logic [31:0] word_at(input logic [511:0] b, input logic [3:0] i);
        logic [8:0] base;
        base = 9'd511 - {i, 5'd0};
        return b[base -: 32];
    endfunction

    // Final-block decode, evaluated on the incoming block; only used on a last-block accept.
    always_comb begin
        len_f   = bus.blk[63:0];
        n_f     = {5'd0, len_f[63:5]};
        e_f     = {32'd0, e_cnt};
        h_f     = (state == WAIT) ? 64'd2 : 64'd0;
        r_f     = n_f - e_f;
        err_f   = (len_f[4:0] != 5'd0) || (n_f < e_f) || (r_f > h_f + 64'd13);
        empty_f = err_f || (r_f == 64'd0);
        if (r_f <= h_f) begin
            held_f = r_f[1:0];
            tail_f = 4'd0;
        end else begin
            held_f = h_f[1:0];
            tail_f = 4'(r_f - h_f);
        end
    end

    always_comb begin
        state_nxt  = state;
        blk_rdy_c  = 1'b0;
        pkt_vld_c  = 1'b0;
        pkt_c      = 32'd0;
        msg_done_c = 1'b0;
        case (state)
            IDLE: begin
                blk_rdy_c = 1'b1;
                if (bus.blk_vld)
                    state_nxt = !bus.blk_last ? HEAD : (empty_f ? FIN : TAIL);
            end
            HEAD: begin
                pkt_vld_c = 1'b1;
                pkt_c     = word_at(blk_q, idx);
                if (bus.pkt_rdy && idx == 4'd13)
                    state_nxt = WAIT;
            end
            WAIT: begin
                blk_rdy_c = 1'b1;
                if (bus.blk_vld)
                    state_nxt = (bus.blk_last && empty_f) ? FIN : HELD;
            end
            HELD: begin
                pkt_vld_c = 1'b1;
                pkt_c     = idx[0] ? held[31:0] : held[63:32];
                if (bus.pkt_rdy && idx == {2'b00, held_cnt} - 4'd1) begin
                    if (!last_q)
                        state_nxt = HEAD;
                    else if (tail_cnt != 4'd0)
                        state_nxt = TAIL;
                    else
                        state_nxt = FIN;
                end
            end
            TAIL: begin
                pkt_vld_c = 1'b1;
                pkt_c     = word_at(blk_q, idx);
                if (bus.pkt_rdy && idx == tail_cnt - 4'd1)
                    state_nxt = FIN;
            end
            FIN: begin
                msg_done_c = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = blk_rdy_c && bus.blk_vld;
    assign xfer   = pkt_vld_c && bus.pkt_rdy;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Held words become committed data only once a further non-final block arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 4'd0;
            held_cnt  <= 2'd0;
            tail_cnt  <= 4'd0;
            last_q    <= 1'b0;
            e_cnt     <= 32'd0;
            held      <= 64'd0;
            mgln_q    <= 64'd0;
            len_err_q <= 1'b0;
        end else begin
            if (accept) begin
                idx    <= 4'd0;
                last_q <= bus.blk_last;
                if (bus.blk_last) begin
                    held_cnt  <= held_f;
                    tail_cnt  <= tail_f;
                    mgln_q    <= len_f;
                    len_err_q <= err_f;
                end else begin
                    held_cnt <= 2'd2;
                    tail_cnt <= 4'd0;
                    e_cnt    <= e_cnt + ((state == WAIT) ? 32'd16 : 32'd14);
                end
            end else if (xfer) begin
                idx <= (state_nxt != state) ? 4'd0 : idx + 4'd1;
            end
            if (state == HEAD && state_nxt == WAIT)
                held <= blk_q[63:0];
            if (state == FIN)
                e_cnt <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            blk_q <= bus.blk;
    end

    assign bus.blk_rdy  = blk_rdy_c;
    assign bus.pkt_vld  = pkt_vld_c;
    assign bus.pkt      = pkt_c;
    assign bus.msg_done = msg_done_c;
    assign bus.mgln     = mgln_q;
    assign bus.len_err  = len_err_q;
endmodule

// File: tb/tb_blk_unpacker.sv
// Bench for blk_unpacker: padded messages built in the bench, expected word stream
// taken from the concatenated block words and the length rules.
module tb_blk_unpacker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blk_unpacker_if bus();
    blk_unpacker dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [31:0] got_q[$];
    int          got_cyc[$];
    int          acc_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [63:0] done_mgln = '0;
    logic        done_err = 1'b0;
    int          stall_cnt = 0;
    int          stab_bad = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pkt = '0;

    logic [31:0] wbuf[$];
    int          nblk;
    logic [31:0] exp_q[$];
    logic        exp_err;
    logic [63:0] exp_mgln;

    always @(negedge clk) begin
        cyc++;
        if (bus.blk_vld && bus.blk_rdy) acc_cyc.push_back(cyc);
        if (bus.pkt_vld && bus.pkt_rdy) begin
            got_q.push_back(bus.pkt);
            got_cyc.push_back(cyc);
        end
        if (bus.msg_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_mgln = bus.mgln;
            done_err  = bus.len_err;
        end
        if (prev_stall && (!bus.pkt_vld || bus.pkt !== prev_pkt)) stab_bad++;
        if (bus.pkt_vld && !bus.pkt_rdy) stall_cnt++;
        prev_stall = bus.pkt_vld && !bus.pkt_rdy;
        prev_pkt   = bus.pkt;
    end

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.pkt_rdy = 1'b1;
            1:       bus.pkt_rdy = ($urandom_range(0, 3) != 0);
            default: bus.pkt_rdy = 1'b0;
        endcase
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic make_msg(input int m, input logic [63:0] lf, input int kf);
        int k;
        k = (kf > 0) ? kf : (m + 18) / 16;
        wbuf.delete();
        for (int i = 0; i < 16 * k; i++)
            wbuf.push_back(i < m ? 32'($urandom) : (i == m ? 32'h8000_0000 : 32'h0));
        wbuf[16*k-2] = lf[63:32];
        wbuf[16*k-1] = lf[31:0];
        nblk = k;
    endtask

    // Output = leading words of the concatenated blocks: N of them, or on error the
    // words already committed before the final block (all but the last two of the earlier blocks).
    task automatic model();
        logic [63:0]     l;
        longint unsigned n, e;
        int              cnt;
        l = {wbuf[16*nblk-2], wbuf[16*nblk-1]};
        n = l >> 5;
        e = (nblk > 1) ? longint'(16 * (nblk - 1) - 2) : 0;
        exp_err = (l[4:0] != 5'd0) || (n < e) || (n > longint'(16 * nblk - 3));
        cnt = exp_err ? int'(e) : int'(n);
        exp_q.delete();
        for (int i = 0; i < cnt; i++) exp_q.push_back(wbuf[i]);
        exp_mgln = l;
    endtask

    function automatic logic [511:0] blk_of(input int bi);
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[511-32*j -: 32] = wbuf[16*bi+j];
        return b;
    endfunction

    task automatic put_block(input logic [511:0] b, input logic last);
        int t;
        bus.blk = b;
        bus.blk_vld = 1'b1;
        bus.blk_last = last;
        t = 0;
        @(negedge clk);
        while (!bus.blk_rdy && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        bus.blk_vld = 1'b0;
        bus.blk_last = 1'b0;
    endtask

    task automatic run_msg(output int base, output int d0);
        int t;
        base = got_q.size();
        d0 = done_cnt;
        for (int bi = 0; bi < nblk; bi++) put_block(blk_of(bi), bi == nblk - 1);
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.blk_rdy !== 1'b1) $display("FAIL reset_blk_rdy got %b want 1", bus.blk_rdy); else passed++;
        checks++; if (bus.pkt_vld !== 1'b0) $display("FAIL reset_pkt_vld got %b want 0", bus.pkt_vld); else passed++;
        checks++; if (bus.pkt !== 32'd0) $display("FAIL reset_pkt got %h want 0", bus.pkt); else passed++;
        checks++; if (bus.msg_done !== 1'b0) $display("FAIL reset_msg_done got %b want 0", bus.msg_done); else passed++;
        checks++; if (bus.len_err !== 1'b0) $display("FAIL reset_len_err got %b want 0", bus.len_err); else passed++;
        checks++; if (bus.mgln !== 64'd0) $display("FAIL reset_mgln got %h want 0", bus.mgln); else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_block();
        int base, d0, ab;
        logic [31:0] want[3];
        want = '{32'h0123_4567, 32'haabb_ccdd, 32'h0123_fedc};
        make_msg(3, 64'h60, 0);
        for (int i = 0; i < 3; i++) wbuf[i] = want[i];
        ab = acc_cyc.size();
        rdy_mode = 0;
        run_msg(base, d0);
        checks++; if (done_cnt - d0 != 1) $display("FAIL single_done got %0d want 1", done_cnt - d0); else passed++;
        checks++;
        if (got_q.size() - base != 3) $display("FAIL single_count got %0d want 3", got_q.size() - base);
        else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_q[base+i] !== want[i]) $display("FAIL single_word%0d got %h want %h", i, got_q[base+i], want[i]); else passed++;
            end
            checks++; if (got_cyc[base] != acc_cyc[ab] + 1) $display("FAIL single_latency got %0d want %0d", got_cyc[base] - acc_cyc[ab], 1); else passed++;
            checks++; if (got_cyc[base+2] != got_cyc[base] + 2) $display("FAIL single_bubble got span %0d want 2", got_cyc[base+2] - got_cyc[base]); else passed++;
            checks++; if (done_cyc != got_cyc[base+2] + 1) $display("FAIL single_done_time got %0d want %0d", done_cyc, got_cyc[base+2] + 1); else passed++;
        end
        checks++; if (done_mgln !== 64'h60) $display("FAIL single_mgln got %h want 60", done_mgln); else passed++;
        checks++; if (done_err !== 1'b0) $display("FAIL single_len_err got %b want 0", done_err); else passed++;
    endtask

    task automatic test_table();
        int          tm[11] = '{14, 15, 20, 0, 3, 3, 40, 20, 13, 29, 20};
        logic [63:0] tl[11] = '{64'h1C0, 64'h1E0, 64'h280, 64'h0, 64'h61, 64'h200,
                                64'd1280, 64'd320, 64'd416, 64'd928, 64'd960};
        int          tk[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int base, d0, n, bad;
        bit ok;
        rdy_mode = 0;
        for (int c = 0; c < 11; c++) begin
            make_msg(tm[c], tl[c], tk[c]);
            model();
            run_msg(base, d0);
            n = got_q.size() - base;
            checks++; if (done_cnt - d0 != 1) $display("FAIL tab%0d_done got %0d want 1", c, done_cnt - d0); else passed++;
            checks++; if (n != exp_q.size()) $display("FAIL tab%0d_count got %0d want %0d", c, n, exp_q.size()); else passed++;
            bad = 0;
            for (int i = 0; i < n && i < exp_q.size(); i++) if (got_q[base+i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) $display("FAIL tab%0d_words got %0d wrong want 0", c, bad); else passed++;
            checks++; if (done_mgln !== exp_mgln) $display("FAIL tab%0d_mgln got %h want %h", c, done_mgln, exp_mgln); else passed++;
            checks++; if (done_err !== exp_err) $display("FAIL tab%0d_len_err got %b want %b", c, done_err, exp_err); else passed++;
            if (c == 2) begin
                ok = (n >= 20);
                if (ok) begin
                    for (int i = 1; i < 20; i++)
                        if (got_cyc[base+i] != got_cyc[base+i-1] + ((i == 14) ? 2 : 1)) ok = 0;
                end
                checks++; if (!ok) $display("FAIL tab20_timing got irregular word spacing (n=%0d) want 14+gap+6", n); else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        int base, d0, s0, b0, t, bad;
        make_msg(12, 64'd384, 0);
        model();
        rdy_mode = 0;
        base = got_q.size();
        d0 = done_cnt;
        s0 = stall_cnt;
        b0 = stab_bad;
        put_block(blk_of(0), 1'b1);
        repeat (5) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1 rdy_mode = 0;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        checks++; if (stall_cnt - s0 != 3) $display("FAIL bp_stall_cycles got %0d want 3", stall_cnt - s0); else passed++;
        checks++; if (stab_bad != b0) $display("FAIL bp_stable got %0d changes want 0", stab_bad - b0); else passed++;
        checks++; if (got_q.size() - base != 12) $display("FAIL bp_count got %0d want 12", got_q.size() - base); else passed++;
        bad = 0;
        for (int i = 0; i < 12 && base + i < got_q.size(); i++) if (got_q[base+i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL bp_words got %0d wrong want 0", bad); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL bp_done got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_reset_mid_head();
        int base, d0, bad;
        make_msg(30, 64'd960, 0);
        rdy_mode = 0;
        d0 = done_cnt;
        put_block(blk_of(0), 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.pkt_vld !== 1'b0) $display("FAIL rstmid_pkt_vld got %b want 0", bus.pkt_vld); else passed++;
        checks++; if (bus.blk_rdy !== 1'b1) $display("FAIL rstmid_blk_rdy got %b want 1", bus.blk_rdy); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (done_cnt != d0) $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); else passed++;
        @(posedge clk);
        #1;
        make_msg(5, 64'd160, 0);
        model();
        run_msg(base, d0);
        bad = (got_q.size() - base != 5) ? 1 : 0;
        for (int i = 0; i < 5 && base + i < got_q.size(); i++) if (got_q[base+i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL rstmid_after got %0d wrong/short want 0", bad); else passed++;
        checks++; if (done_err !== 1'b0) $display("FAIL rstmid_len_err got %b want 0", done_err); else passed++;
    endtask

    task automatic test_random();
        int base, d0, n, bad, m, k, sel;
        logic [63:0] l;
        for (int it = 0; it < 14; it++) begin
            m = $urandom_range(0, 60);
            k = (m + 18) / 16;
            l = 64'(m) << 5;
            sel = $urandom_range(0, 5);
            if (sel == 0) l = l | 64'($urandom_range(1, 31));
            if (sel == 1) l = 64'($urandom_range(0, 16 * k)) << 5;
            make_msg(m, l, 0);
            model();
            rdy_mode = 1;
            run_msg(base, d0);
            rdy_mode = 0;
            n = got_q.size() - base;
            bad = (n != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < n && i < exp_q.size(); i++) if (got_q[base+i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) $display("FAIL rnd%0d_stream got %0d words (%0d wrong) want %0d", it, n, bad, exp_q.size()); else passed++;
            checks++; if (done_err !== exp_err || done_mgln !== exp_mgln || done_cnt - d0 != 1)
                $display("FAIL rnd%0d_status got err=%b mgln=%h done=%0d want err=%b mgln=%h done=1",
                         it, done_err, done_mgln, done_cnt - d0, exp_err, exp_mgln);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.blk = '0;
        bus.blk_vld = 1'b0;
        bus.blk_last = 1'b0;
        test_reset();
        test_single_block();
        test_table();
        test_backpressure();
        test_reset_mid_head();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
